dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-side memory bridge for the M stage of the 5-stage MIPS pipeline. It converts the M-stage access (`aluoutM` address, byte-positioned `writedata_decodedM`, and the `readEnM`/`writeEnM` byte masks) into a single-outstanding sram-like bus transaction. It raises a stall request to the hazard unit until the access completes, and returns the raw read word that feeds `readdataM`. Blocking loads and stores on a variable-latency bus are its only purpose; byte lane decode stays in `memInsDecode`.

## Interface
- No parameters; the address and data buses are fixed at 32 bits.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-low reset (asserted when 0).
- `addrM` in 32: M-stage effective address (`aluoutM`).
- `wdataM` in 32: byte-positioned store data.
- `renM` in 4: read byte mask; nonzero means load.
- `wenM` in 4: write byte mask; nonzero means store. `renM` and `wenM` are never both nonzero.
- `flushM` in 1: M-stage instruction is being squashed this cycle.
- `m_hold` in 1: M register will not advance this cycle for reasons other than this block.
- `stall_req` out 1: to hazard unit; holds F..M while 1.
- `rdataM` out 32: load data to the pipeline; valid while `stall_req`=0 for a load.
- `data_req` out 1: bus request.
- `data_wr` out 1: bus write.
- `data_size` out 2: 0=byte, 1=half, 2=word.
- `data_addr` out 32: bus address.
- `data_wdata` out 32: bus write data.
- `data_addr_ok` in 1: request accepted this cycle.
- `data_rdata` in 32: bus read data.
- `data_data_ok` in 1: response this cycle; arrives at least 1 cycle after its `data_addr_ok`.

## Operation
- `acc` = (`renM`|`wenM`) != 0 and not `flushM`.
- Size: mask popcount 4 → 2, 2 → 1, 1 → 0. `data_addr` = `addrM` unmodified. `data_wdata` = `wdataM`.
- States and behaviour:
  - IDLE: if `acc`, drive `data_req`=1 combinationally from the live M inputs and latch the request into hold regs. Go to WAIT if `data_addr_ok`, else go to REQ. `stall_req`=`acc`.
  - REQ: drive `data_req`=1 from the hold regs; all fields stay stable. On `data_addr_ok`, go to WAIT. `stall_req`=1.
  - WAIT: `data_req`=0. On `data_data_ok`:
    - `stall_req`=0 and `rdataM`=`data_rdata` (bypass); latch `data_rdata` into `rbuf`.
    - Go to DONE if `m_hold`, else go to IDLE.
    - Before `data_data_ok`, `stall_req`=1.
  - DONE: access complete while the pipeline is still held. `stall_req`=0 and `rdataM`=`rbuf`. Never re-issue. Go to IDLE when `m_hold`=0.
- Flush: `flushM` in REQ or WAIT sets the `discard` flag.
  - The request must still be held until `data_addr_ok`, then drained until `data_data_ok`.
  - While `discard`=1, `stall_req`=`acc` (the new M instruction waits) and `rdataM` is not updated from the bus.
  - On drain completion, clear `discard` and go to IDLE; a pending new access is issued the next cycle.
- `flushM` in DONE: go to IDLE.
- At most one transaction outstanding; `data_req` is never asserted in WAIT.

## Timing
- Reset (rst=0 at an edge) values:
  - state=IDLE, `discard`=0, `rbuf`=0.
  - Outputs are combinational from this state: `data_req`=0 and `stall_req`=0 when M is empty, `rdataM`=0.
- Reset in REQ/WAIT abandons the transaction. The bus is also reset, so no drain occurs.
- Best-case latency: `addr_ok` arrives in the issue cycle and `data_ok` one cycle later, so `stall_req` is high for exactly 1 cycle per access.
- Same-cycle `data_data_ok` and `flushM`: the data is discarded and the FSM goes to IDLE.

## Structure
- Shared package/header: state encodings (IDLE=0, REQ=1, WAIT=2, DONE=3) and size codes (SZ_B, SZ_H, SZ_W).
- No sub-module is needed. The mask-to-size function stays inline.
- Instantiated in `datapath` beside `memInsDecode`. `stall_req` is ORed into the hazard stall chain; `m_hold` = hazard stall excluding `stall_req`.

## Test plan
- Load, word: renM=4'b1111, addrM=0x100, addr_ok in the issue cycle, data_ok 2 cycles later with 0xDEADBEEF → data_req=1 for 1 cycle, data_size=2, data_wr=0, stall_req=1 for 2 cycles, rdataM=0xDEADBEEF in the data_ok cycle.
- Store, byte: wenM=4'b0100, addrM=0x102, wdataM=0x00AB0000 → data_wr=1, data_size=0, data_addr=0x102, data_wdata=0x00AB0000.
- Delayed accept: addr_ok withheld for 3 cycles while addrM changes → data_req held for 4 cycles with the original address and data; stall_req=1 throughout.
- Held pipeline: data_ok=0x1234 with m_hold=1 for 3 more cycles → no new data_req; rdataM=0x1234 and stall_req=0 in all those cycles.
- Flush drain: flushM in WAIT and a new load in M → stall_req stays 1, the old data_ok data never appears on rdataM, and the new data_req is asserted the cycle after the old data_ok.
- Reset mid-WAIT: rst=0 for 1 cycle → state=IDLE and data_req=0; the next load issues normally.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types for the M-stage data memory bridge: FSM states, bus size codes
// and the latched request payload.
package dmem_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_bridge_if.sv
// sram-like data bus: one request channel (req/addr_ok) and one response
// channel (data_ok/rdata).
interface dmem_bridge_if;

    logic                                  data_req;
    logic                                  data_wr;
    logic [dmem_bridge_pkg::SIZE_W-1:0]    data_size;
    logic [dmem_bridge_pkg::ADDR_W-1:0]    data_addr;
    logic [dmem_bridge_pkg::DATA_W-1:0]    data_wdata;
    logic                                  data_addr_ok;
    logic [dmem_bridge_pkg::DATA_W-1:0]    data_rdata;
    logic                                  data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok
    );

endinterface

// File: rtl/dmem_bridge.sv
// Turns the M-stage load/store into one blocking sram-like bus transaction,
// stalling the pipeline until the response returns.
module dmem_bridge
    import dmem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [DATA_W-1:0] wdataM,
    input  logic [MASK_W-1:0] renM,
    input  logic [MASK_W-1:0] wenM,
    input  logic              flushM,
    input  logic              m_hold,
    output logic              stall_req,
    output logic [DATA_W-1:0] rdataM,
    dmem_bridge_if.master     bus
);

    state_e            state_q, state_d;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    req_t              hold_q, hold_d;

    logic [MASK_W-1:0] mask;
    logic              acc;
    logic [SIZE_W-1:0] live_size;
    req_t              live;
    req_t              out_c;
    logic              req_c;

    assign mask = renM | wenM;
    assign acc  = (mask != '0) && !flushM;

    // Byte mask popcount selects the bus transfer size.
    always_comb begin
        live_size = SZ_B;
        if ($countones(mask) == 4) begin
            live_size = SZ_W;
        end else if ($countones(mask) == 2) begin
            live_size = SZ_H;
        end
    end

    assign live = '{wr: (wenM != '0), size: live_size, addr: addrM, wdata: wdataM};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            discard_q <= 1'b0;
            rbuf_q    <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            rbuf_q    <= rbuf_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        rbuf_d    = rbuf_q;
        hold_d    = hold_q;
        out_c     = hold_q;
        req_c     = 1'b0;
        stall_req = 1'b0;
        rdataM    = rbuf_q;

        unique case (state_q)
            ST_IDLE: begin
                stall_req = acc;
                if (acc) begin
                    req_c   = 1'b1;
                    out_c   = live;
                    hold_d  = live;
                    state_d = bus.data_addr_ok ? ST_WAIT : ST_REQ;
                end
            end

            ST_REQ: begin
                req_c     = 1'b1;
                stall_req = discard_q ? acc : 1'b1;
                if (flushM) begin
                    discard_d = 1'b1;
                end
                if (bus.data_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                stall_req = discard_q ? acc : 1'b1;
                if (flushM) begin
                    discard_d = 1'b1;
                end
                if (bus.data_data_ok) begin
                    // A squashed access drains silently; the waiting instruction issues next cycle.
                    if (discard_q || flushM) begin
                        discard_d = 1'b0;
                        stall_req = acc;
                        state_d   = ST_IDLE;
                    end else begin
                        stall_req = 1'b0;
                        rdataM    = bus.data_rdata;
                        rbuf_d    = bus.data_rdata;
                        state_d   = m_hold ? ST_DONE : ST_IDLE;
                    end
                end
            end

            ST_DONE: begin
                if (flushM || !m_hold) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.data_req   = req_c;
    assign bus.data_wr    = out_c.wr;
    assign bus.data_size  = out_c.size;
    assign bus.data_addr  = out_c.addr;
    assign bus.data_wdata = out_c.wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scenario bench for dmem_bridge: directed pipeline situations plus random
// loads/stores served from a word-array memory model.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] addrM;
    logic [31:0] wdataM;
    logic [3:0]  renM;
    logic [3:0]  wenM;
    logic        flushM;
    logic        m_hold;
    logic        stall_req;
    logic [31:0] rdataM;

    dmem_bridge_if bus();

    dmem_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .addrM     (addrM),
        .wdataM    (wdataM),
        .renM      (renM),
        .wenM      (wenM),
        .flushM    (flushM),
        .m_hold    (m_hold),
        .stall_req (stall_req),
        .rdataM    (rdataM),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_rbuf;
    logic [31:0] mem [int unsigned];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        renM             = 4'b0;
        wenM             = 4'b0;
        flushM           = 1'b0;
        m_hold           = 1'b0;
        addrM            = $urandom;
        wdataM           = $urandom;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctl: got req/stall %b want 00", {bus.data_req, stall_req});
        end
        n_checks++;
        if (rdataM !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 00000000", rdataM);
        end
        exp_rbuf = 32'h0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load_word();
        renM = 4'hF; addrM = 32'h100; bus.data_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, bus.data_wr, bus.data_size, stall_req} !== 5'b1_0_10_1) begin
            n_fail++;
            $display("FAIL load_issue: got req/wr/size/stall %b want 10101",
                     {bus.data_req, bus.data_wr, bus.data_size, stall_req});
        end
        n_checks++;
        if (bus.data_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL load_addr: got %h want 00000100", bus.data_addr);
        end
        tick();
        bus.data_addr_ok = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL load_wait: got req/stall %b want 01", {bus.data_req, stall_req});
        end
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req, rdataM} !== {2'b00, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL load_data: got req/stall %b rdata %h want 00 deadbeef",
                     {bus.data_req, stall_req}, rdataM);
        end
        exp_rbuf = 32'hDEADBEEF;
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL load_after: got req/stall %b want 00", {bus.data_req, stall_req});
        end
        tick();
    endtask

    task automatic test_store_byte();
        wenM = 4'b0100; addrM = 32'h102; wdataM = 32'h00AB0000; bus.data_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, bus.data_wr, bus.data_size, stall_req} !== 5'b1_1_00_1) begin
            n_fail++;
            $display("FAIL store_issue: got req/wr/size/stall %b want 11001",
                     {bus.data_req, bus.data_wr, bus.data_size, stall_req});
        end
        n_checks++;
        if ({bus.data_addr, bus.data_wdata} !== {32'h102, 32'h00AB0000}) begin
            n_fail++;
            $display("FAIL store_fields: got addr %h wdata %h want 00000102 00ab0000",
                     bus.data_addr, bus.data_wdata);
        end
        tick();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL store_done: got req/stall %b want 00", {bus.data_req, stall_req});
        end
        exp_rbuf = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_delayed_accept();
        wenM = 4'hF; addrM = 32'h300; wdataM = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                addrM  = $urandom;
                wdataM = $urandom;
            end
            bus.data_addr_ok = (i == 3);
            @(negedge clk);
            n_checks++;
            if ({bus.data_req, bus.data_wr, stall_req, bus.data_addr, bus.data_wdata} !==
                {3'b111, 32'h300, 32'hCAFEF00D}) begin
                n_fail++;
                $display("FAIL delayed_hold[%0d]: got req/wr/stall %b addr %h wdata %h want 111 00000300 cafef00d",
                         i, {bus.data_req, bus.data_wr, stall_req}, bus.data_addr, bus.data_wdata);
            end
            tick();
        end
        bus.data_addr_ok = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL delayed_wait: got req/stall %b want 01", {bus.data_req, stall_req});
        end
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL delayed_done: got req/stall %b want 00", {bus.data_req, stall_req});
        end
        exp_rbuf = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_held_pipeline();
        renM = 4'hF; addrM = 32'h400; bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234; m_hold = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req, rdataM} !== {2'b00, 32'h1234}) begin
            n_fail++;
            $display("FAIL held_data: got req/stall %b rdata %h want 00 00001234",
                     {bus.data_req, stall_req}, rdataM);
        end
        exp_rbuf = 32'h1234;
        tick();
        bus.data_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.data_rdata = $urandom;
            m_hold = (i < 3);
            @(negedge clk);
            n_checks++;
            if ({bus.data_req, stall_req, rdataM} !== {2'b00, 32'h1234}) begin
                n_fail++;
                $display("FAIL held_done[%0d]: got req/stall %b rdata %h want 00 00001234",
                         i, {bus.data_req, stall_req}, rdataM);
            end
            tick();
        end
        idle();
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL held_release: got req/stall %b want 00", {bus.data_req, stall_req});
        end
        tick();
    endtask

    task automatic test_flush_drain();
        renM = 4'hF; addrM = 32'h500; bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0; flushM = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_cycle: got req/stall %b want 01", {bus.data_req, stall_req});
        end
        tick();
        flushM = 1'b0; addrM = 32'h600;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_drain: got req/stall %b want 01", {bus.data_req, stall_req});
        end
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req, rdataM} !== {2'b01, exp_rbuf}) begin
            n_fail++;
            $display("FAIL flush_discard: got req/stall %b rdata %h want 01 %h",
                     {bus.data_req, stall_req}, rdataM, exp_rbuf);
        end
        tick();
        bus.data_data_ok = 1'b0; bus.data_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req, bus.data_addr} !== {2'b11, 32'h600}) begin
            n_fail++;
            $display("FAIL flush_reissue: got req/stall %b addr %h want 11 00000600",
                     {bus.data_req, stall_req}, bus.data_addr);
        end
        tick();
        bus.data_addr_ok = 1'b0;
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55AA55AA;
        @(negedge clk);
        n_checks++;
        if ({stall_req, rdataM} !== {1'b0, 32'h55AA55AA}) begin
            n_fail++;
            $display("FAIL flush_newdata: got stall %b rdata %h want 0 55aa55aa", stall_req, rdataM);
        end
        exp_rbuf = 32'h55AA55AA;
        tick();
        idle();
        // Response and flush in the same cycle.
        renM = 4'hF; addrM = 32'h700; bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; flushM = 1'b1;
        bus.data_rdata = 32'h0BADF00D;
        @(negedge clk);
        n_checks++;
        if ({stall_req, rdataM} !== {1'b0, exp_rbuf}) begin
            n_fail++;
            $display("FAIL flush_sameok: got stall %b rdata %h want 0 %h", stall_req, rdataM, exp_rbuf);
        end
        tick();
        bus.data_data_ok = 1'b0; flushM = 1'b0; addrM = 32'h800; bus.data_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, bus.data_addr} !== {1'b1, 32'h800}) begin
            n_fail++;
            $display("FAIL flush_sameok_next: got req %b addr %h want 1 00000800", bus.data_req, bus.data_addr);
        end
        tick();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0;
        exp_rbuf = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_reset_mid_wait();
        renM = 4'hF; addrM = 32'h900; bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstwait_pre: got req/stall %b want 01", {bus.data_req, stall_req});
        end
        tick();
        rst = 1'b1;
        idle();
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req, rdataM} !== {2'b00, 32'h0}) begin
            n_fail++;
            $display("FAIL rstwait_post: got req/stall %b rdata %h want 00 00000000",
                     {bus.data_req, stall_req}, rdataM);
        end
        exp_rbuf = 32'h0;
        tick();
        renM = 4'hF; addrM = 32'hA00; bus.data_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.data_req, stall_req, bus.data_addr} !== {2'b11, 32'hA00}) begin
            n_fail++;
            $display("FAIL rstwait_issue: got req/stall %b addr %h want 11 00000a00",
                     {bus.data_req, stall_req}, bus.data_addr);
        end
        tick();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h600DCAFE;
        @(negedge clk);
        n_checks++;
        if ({stall_req, rdataM} !== {1'b0, 32'h600DCAFE}) begin
            n_fail++;
            $display("FAIL rstwait_data: got stall %b rdata %h want 0 600dcafe", stall_req, rdataM);
        end
        exp_rbuf = 32'h600DCAFE;
        tick();
        idle();
    endtask

    task automatic test_random();
        int unsigned widx, sz, off, d_acc, d_rsp, gap;
        logic        is_store;
        logic [3:0]  m;
        logic [31:0] a, wd, word, rsp;
        for (int t = 0; t < 80; t++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < int'(gap); g++) begin
                idle();
                @(negedge clk);
                n_checks++;
                if ({bus.data_req, stall_req} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rand_idle[%0d]: got req/stall %b want 00", t, {bus.data_req, stall_req});
                end
                tick();
            end
            idle();
            is_store = 1'($urandom_range(0, 1));
            sz       = $urandom_range(0, 2);
            widx     = $urandom_range(0, 15);
            off      = (sz == 2) ? 0 : (sz == 1) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
            m        = (sz == 2) ? 4'hF : (sz == 1) ? (4'b0011 << off) : (4'b0001 << off);
            a        = 32'h1000 + 32'(widx * 4 + off);
            wd       = $urandom;
            for (int b = 0; b < 4; b++) if (!m[b]) wd[8*b +: 8] = 8'h00;
            word     = mem.exists(widx) ? mem[widx] : 32'h0;
            d_acc    = $urandom_range(0, 3);
            d_rsp    = $urandom_range(1, 3);
            addrM = a; wdataM = wd;
            if (is_store) wenM = m; else renM = m;
            for (int k = 0; k <= int'(d_acc + d_rsp); k++) begin
                bus.data_addr_ok = (k == int'(d_acc));
                bus.data_data_ok = (k == int'(d_acc + d_rsp));
                rsp = is_store ? $urandom : word;
                bus.data_rdata = bus.data_data_ok ? rsp : $urandom;
                @(negedge clk);
                n_checks++;
                if ({bus.data_req, stall_req} !== {k <= int'(d_acc), k != int'(d_acc + d_rsp)}) begin
                    n_fail++;
                    $display("FAIL rand_ctl[%0d.%0d]: got req/stall %b want %b", t, k,
                             {bus.data_req, stall_req}, {k <= int'(d_acc), k != int'(d_acc + d_rsp)});
                end
                if (k <= int'(d_acc)) begin
                    n_checks++;
                    if ({bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata} !==
                        {is_store, 2'(sz), a, wd}) begin
                        n_fail++;
                        $display("FAIL rand_req[%0d.%0d]: got wr %b size %0d addr %h wdata %h want %b %0d %h %h",
                                 t, k, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata,
                                 is_store, sz, a, wd);
                    end
                end
                if (bus.data_data_ok) begin
                    if (!is_store) begin
                        n_checks++;
                        if (rdataM !== word) begin
                            n_fail++;
                            $display("FAIL rand_load[%0d]: got rdata %h want %h", t, rdataM, word);
                        end
                    end else begin
                        for (int b = 0; b < 4; b++) if (m[b]) word[8*b +: 8] = wd[8*b +: 8];
                        mem[widx] = word;
                    end
                    exp_rbuf = rsp;
                end
                tick();
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_delayed_accept();
        test_held_pipeline();
        test_flush_drain();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
